// File: rtl/rr_sel_arb_8.sv
// Round-robin arbiter producing the registered 3-bit select for an 8-to-1 mux.
// One-hot grant pulses on each accepted transfer; priority rotates past the winner.
module rr_sel_arb_8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       out_rdy,
  output logic [2:0] sel,
  output logic       out_val,
  output logic [7:0] grant
);

  // Slot occupancy is the whole FSM; FULL is exactly out_val=1.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] ptr_eff;
  logic [2:0] winner;
  logic [7:0] cand;
  logic       xfer;
  logic       load;
  logic       cand_any;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= EMPTY;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Handshake, rotating priority search and datapath next-state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    xfer     = (state_q == FULL) && out_rdy && !reset;
    load     = (state_q == EMPTY) || out_rdy;
    ptr_eff  = xfer ? sel_q + 3'd1 : ptr_q;
    cand     = req & ~grant;
    cand_any = |cand;
    winner   = ptr_eff;
    // Scan from farthest to nearest so the closest set bit after ptr_eff wins.
    for (int i = 7; i >= 0; i--) begin
      if (cand[ptr_eff + 3'(i)]) winner = ptr_eff + 3'(i);
    end
    sel_d = (load && cand_any) ? winner : sel_q;
    ptr_d = ptr_eff;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (cand_any) state_d = FULL;
      FULL:  if (out_rdy) state_d = cand_any ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: select and valid straight from registers, grant from the live handshake.
  always_comb begin
    sel     = sel_q;
    out_val = (state_q == FULL);
    grant   = 8'h00;
    if (xfer) grant[sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_rr_sel_arb_8.sv
// Directed bench for rr_sel_arb_8: expectations are queued as each step is
// driven and popped for comparison mid-cycle, after the DUT has settled.
module tb_rr_sel_arb_8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       out_rdy;
  logic [2:0] sel;
  logic       out_val;
  logic [7:0] grant;

  typedef struct {
    logic       val;
    logic [2:0] sel;
    logic [7:0] grant;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  rr_sel_arb_8 dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .out_rdy (out_rdy),
    .sel     (sel),
    .out_val (out_val),
    .grant   (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare at the falling edge.
  task automatic step(input logic rst, input logic [7:0] r, input logic rdy,
                      input logic ev, input logic [2:0] es, input logic [7:0] eg,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    req     = r;
    out_rdy = rdy;
    e.val   = ev;
    e.sel   = es;
    e.grant = eg;
    e.tag   = tag;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, ".out_val"}, {7'd0, out_val}, {7'd0, e.val});
    check({e.tag, ".sel"},     {5'd0, sel},     {5'd0, e.sel});
    check({e.tag, ".grant"},   grant,           e.grant);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 8'h00;
    out_rdy = 1'b0;
    @(posedge clk);
    step(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, "reset");
    step(1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, "reset_rdy");

    // Idle: no requests, out_rdy high.
    for (int i = 0; i < 5; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, $sformatf("idle%0d", i));

    // All requesting: empty slot first, then sel 0..7,0 at one transfer per cycle.
    step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, "all_fill");
    for (int i = 0; i < 9; i++)
      step(1'b0, 8'hFF, 1'b1, 1'b1, 3'(i % 8), 8'h01 << (i % 8), $sformatf("all%0d", i));
    // Drain: sel=1 is granted, nothing left, slot empties with sel held, ptr=2.
    step(1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h02, "drain");
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, "drained");

    // Backpressure on requesters 2 and 3.
    step(1'b0, 8'h0C, 1'b0, 1'b0, 3'd1, 8'h00, "bp_fill");
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'h0C, 1'b0, 1'b1, 3'd2, 8'h00, $sformatf("bp_hold%0d", i));
    step(1'b0, 8'h0C, 1'b1, 1'b1, 3'd2, 8'h04, "bp_g2");
    step(1'b0, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, "bp_g3");
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, "bp_empty");

    // Wrap-around: grant 5 alone (ptr->6), then 0 beats 5 on the wrapped search.
    step(1'b0, 8'h20, 1'b1, 1'b0, 3'd3, 8'h00, "wr_fill5");
    step(1'b0, 8'h20, 1'b1, 1'b1, 3'd5, 8'h20, "wr_g5");
    step(1'b0, 8'h21, 1'b1, 1'b0, 3'd5, 8'h00, "wr_fill");
    step(1'b0, 8'h21, 1'b1, 1'b1, 3'd0, 8'h01, "wr_g0");
    step(1'b0, 8'h20, 1'b1, 1'b1, 3'd5, 8'h20, "wr_g5b");
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, "wr_empty");

    // Lone requester 4 held high: valid every other cycle.
    step(1'b0, 8'h10, 1'b1, 1'b0, 3'd5, 8'h00, "lone_fill");
    step(1'b0, 8'h10, 1'b1, 1'b1, 3'd4, 8'h10, "lone_v0");
    step(1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 8'h00, "lone_e0");
    step(1'b0, 8'h10, 1'b1, 1'b1, 3'd4, 8'h10, "lone_v1");
    step(1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 8'h00, "lone_e1");
    step(1'b0, 8'h10, 1'b1, 1'b1, 3'd4, 8'h10, "lone_v2");
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00, "lone_done");

    // Reset mid-operation: ptr=5, run 5,6,7,0,1,2 then reset while sel=3 is valid.
    step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd4, 8'h00, "rm_fill");
    for (int i = 0; i < 6; i++)
      step(1'b0, 8'hFF, 1'b1, 1'b1, 3'((5 + i) % 8), 8'h01 << ((5 + i) % 8),
           $sformatf("rm_run%0d", i));
    step(1'b1, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h00, "rm_reset");
    step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, "rm_after");
    step(1'b0, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, "rm_refill");
    step(1'b0, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02, "rm_next");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed=%0d leftover required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
